// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: chunk sizing and
// parameter legality, evaluated at elaboration time.
package pipelined_adder_pkg;

  function automatic int cla_chunk(input int numbits, input int stages);
    return (stages > 0) ? numbits / stages : 0;
  endfunction

  function automatic bit cla_params_ok(input int numbits, input int stages);
    if (stages < 1 || numbits < 1) return 1'b0;
    return (numbits % stages) == 0;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla.sv
// Combinational carry-lookahead slice: every carry is a flat sum of
// generate terms gated by the propagate run above them, not a ripple chain.
module nBitCarryLookAheadAdder #(
  parameter int NUMBITS = 4
) (
  input  logic [NUMBITS-1:0] i_a,
  input  logic [NUMBITS-1:0] i_b,
  input  logic               i_cin,
  output logic [NUMBITS-1:0] o_sum,
  output logic               o_cout
);

  logic [NUMBITS-1:0] w_g;
  logic [NUMBITS-1:0] w_p;
  logic [NUMBITS:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    logic w_cy;
    logic w_pp;
    w_c    = '0;
    w_c[0] = i_cin;
    w_cy   = 1'b0;
    w_pp   = 1'b1;
    for (int i = 0; i < NUMBITS; i++) begin
      w_cy = 1'b0;
      w_pp = 1'b1;
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
      for (int j = i; j >= 0; j--) begin
        w_cy = w_cy | (w_g[j] & w_pp);
        w_pp = w_pp & w_p[j];
      end
      w_c[i+1] = w_cy | (w_pp & i_cin);
    end
  end

  assign o_sum  = w_p ^ w_c[NUMBITS-1:0];
  assign o_cout = w_c[NUMBITS];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: stage k resolves operand chunk k with a CLA slice
// and registers the carry forward; bubble-collapsing valid/ready flow control.
module pipelined_cla_adder
  import pipelined_adder_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int STAGES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] a_in,
  input  logic [NUMBITS-1:0] b_in,
  input  logic               c_in,
  input  logic               sub_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] s_out,
  output logic               c_out,
  output logic               ovf_out
);

  localparam int CHUNK = cla_chunk(NUMBITS, STAGES);
  localparam int MSB   = NUMBITS - 1;

  if (!cla_params_ok(NUMBITS, STAGES)) begin : g_bad_params
    $error("pipelined_cla_adder: STAGES must be >= 1 and divide NUMBITS");
  end

  // a/b carry the not-yet-added upper chunks; sum collects resolved chunks
  typedef struct packed {
    logic               vld;
    logic               cy;
    logic               ovf;
    logic [NUMBITS-1:0] sum;
    logic [NUMBITS-1:0] a;
    logic [NUMBITS-1:0] b;
  } stage_t;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stage_t           w_src;
    stage_t           w_nxt;
    stage_t           r_stg;
    logic             w_rdy;
    logic             w_rdy_dn;
    logic             w_cy;
    logic [CHUNK-1:0] w_sum;

    if (k == 0) begin : g_head
      always_comb begin
        w_src     = '0;
        w_src.vld = in_valid;
        w_src.cy  = c_in;
        w_src.a   = a_in;
        w_src.b   = sub_in ? ~b_in : b_in;
      end
    end else begin : g_link
      assign w_src = g_stg[k-1].r_stg;
    end

    if (k == STAGES - 1) begin : g_tail
      assign w_rdy_dn = out_ready;
    end else begin : g_mid
      assign w_rdy_dn = g_stg[k+1].w_rdy;
    end

    assign w_rdy = !r_stg.vld || w_rdy_dn;

    nBitCarryLookAheadAdder #(.NUMBITS(CHUNK)) u_cla (
      .i_a   (w_src.a[k*CHUNK +: CHUNK]),
      .i_b   (w_src.b[k*CHUNK +: CHUNK]),
      .i_cin (w_src.cy),
      .o_sum (w_sum),
      .o_cout(w_cy)
    );

    always_comb begin
      w_nxt                     = w_src;
      w_nxt.cy                  = w_cy;
      w_nxt.sum[k*CHUNK +: CHUNK] = w_sum;
      if (k == STAGES - 1)
        w_nxt.ovf = (w_src.a[MSB] == w_src.b[MSB]) && (w_nxt.sum[MSB] != w_src.a[MSB]);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_stg <= '0;
      end else if (w_rdy) begin
        if (w_src.vld) r_stg     <= w_nxt;
        else           r_stg.vld <= 1'b0;
      end
    end
  end

  assign in_ready  = g_stg[0].w_rdy && !reset;
  assign out_valid = g_stg[STAGES-1].r_stg.vld;
  assign s_out     = g_stg[STAGES-1].r_stg.sum;
  assign c_out     = g_stg[STAGES-1].r_stg.cy;
  assign ovf_out   = g_stg[STAGES-1].r_stg.ovf;

  // operands are fully consumed by the last slice; its copies are dead
  logic w_unused;
  assign w_unused = ^{g_stg[STAGES-1].r_stg.a, g_stg[STAGES-1].r_stg.b};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboarded bench: directed + random traffic on a 16b/4-stage unit and an
// exhaustive sweep on a 4b/2-stage unit, against an integer reference model.
module tb_pipelined_cla_adder;
  localparam int NW = 16, SW = 4, NN = 4, SN = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          iv_w, ir_w, ci_w, sub_w, ov_w, c_w, ovf_w, ordy_w;
  logic          ordy_dir_w, ordy_rnd_w, rnd_en_w;
  logic [NW-1:0] a_w, b_w, s_w;
  logic          iv_n, ir_n, ci_n, sub_n, ov_n, c_n, ovf_n, ordy_n;
  logic          ordy_dir_n, ordy_rnd_n, rnd_en_n;
  logic [NN-1:0] a_n, b_n, s_n;

  assign ordy_w = rnd_en_w ? ordy_rnd_w : ordy_dir_w;
  assign ordy_n = rnd_en_n ? ordy_rnd_n : ordy_dir_n;

  pipelined_cla_adder #(.NUMBITS(NW), .STAGES(SW)) u_dut_w (
    .clk(clk), .reset(reset), .in_valid(iv_w), .in_ready(ir_w),
    .a_in(a_w), .b_in(b_w), .c_in(ci_w), .sub_in(sub_w),
    .out_valid(ov_w), .out_ready(ordy_w), .s_out(s_w), .c_out(c_w), .ovf_out(ovf_w));

  pipelined_cla_adder #(.NUMBITS(NN), .STAGES(SN)) u_dut_n (
    .clk(clk), .reset(reset), .in_valid(iv_n), .in_ready(ir_n),
    .a_in(a_n), .b_in(b_n), .c_in(ci_n), .sub_in(sub_n),
    .out_valid(ov_n), .out_ready(ordy_n), .s_out(s_n), .c_out(c_n), .ovf_out(ovf_n));

  int n_cmp = 0, n_bad = 0;
  int n_pop_w = 0, n_pop_n = 0;

  typedef struct { longint cs; bit ovf; } exp_t;
  exp_t q_w[$], q_n[$];

  // {carry,sum} as plain integer addition; overflow as a signed range test
  function automatic exp_t model(int n, longint a, longint b, bit cin, bit sub);
    longint m    = (64'sd1 <<< n) - 1;
    longint half = 64'sd1 <<< (n - 1);
    longint bp, sa, sb, sv;
    exp_t   e;
    bp    = sub ? (~b & m) : (b & m);
    e.cs  = (a & m) + bp + longint'(cin);
    sa    = ((a & m) >= half) ? (a & m) - (64'sd1 <<< n) : (a & m);
    sb    = (bp >= half) ? bp - (64'sd1 <<< n) : bp;
    sv    = sa + sb + longint'(cin);
    e.ovf = (sv >= half) || (sv < -half);
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // scoreboard push on accepted handshakes
  initial forever begin
    @(negedge clk);
    if (!reset && iv_w && ir_w) q_w.push_back(model(NW, longint'(a_w), longint'(b_w), ci_w, sub_w));
    if (!reset && iv_n && ir_n) q_n.push_back(model(NN, longint'(a_n), longint'(b_n), ci_n, sub_n));
  end

  // monitor: wide unit
  initial begin
    logic          stl;
    logic [NW+2:0] hold;
    exp_t          e;
    stl = 1'b0; hold = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q_w.delete();
        stl = 1'b0;
      end else begin
        if (stl) check("hold_w", {ov_w, c_w, ovf_w, s_w}, hold);
        if (ov_w && ordy_w) begin
          n_pop_w++;
          if (q_w.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out_w_unexpected: got s=0x%0h, want no output", s_w);
          end else begin
            e = q_w.pop_front();
            check("sum_w", {c_w, s_w}, e.cs);
            check("ovf_w", ovf_w, e.ovf);
          end
        end
        stl  = ov_w && !ordy_w;
        hold = {ov_w, c_w, ovf_w, s_w};
      end
    end
  end

  // monitor: narrow unit
  initial begin
    logic          stl;
    logic [NN+2:0] hold;
    exp_t          e;
    stl = 1'b0; hold = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q_n.delete();
        stl = 1'b0;
      end else begin
        if (stl) check("hold_n", {ov_n, c_n, ovf_n, s_n}, hold);
        if (ov_n && ordy_n) begin
          n_pop_n++;
          if (q_n.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out_n_unexpected: got s=0x%0h, want no output", s_n);
          end else begin
            e = q_n.pop_front();
            check("sum_n", {c_n, s_n}, e.cs);
            check("ovf_n", ovf_n, e.ovf);
          end
        end
        stl  = ov_n && !ordy_n;
        hold = {ov_n, c_n, ovf_n, s_n};
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    ordy_rnd_w = 1'($urandom_range(0, 1));
    ordy_rnd_n = 1'($urandom_range(0, 1));
  end

  task automatic send_w(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic ci, input logic sb);
    bit got = 1'b0;
    int t   = 0;
    a_w = a; b_w = b; ci_w = ci; sub_w = sb; iv_w = 1'b1;
    do begin
      @(negedge clk); got = ir_w;
      @(posedge clk); #1; t++;
    end while (!got && t < 1000);
    if (!got) begin n_cmp++; n_bad++; $display("FAIL send_w_timeout: got no in_ready, want accept"); end
    iv_w = 1'b0;
  endtask

  task automatic send_n(input logic [NN-1:0] a, input logic [NN-1:0] b, input logic ci, input logic sb);
    bit got = 1'b0;
    int t   = 0;
    a_n = a; b_n = b; ci_n = ci; sub_n = sb; iv_n = 1'b1;
    do begin
      @(negedge clk); got = ir_n;
      @(posedge clk); #1; t++;
    end while (!got && t < 1000);
    if (!got) begin n_cmp++; n_bad++; $display("FAIL send_n_timeout: got no in_ready, want accept"); end
    iv_n = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q_w.size() != 0 || q_n.size() != 0) && t < 10000) begin
      @(posedge clk); t++;
    end
    #1;
    check("drain_w_empty", 64'(q_w.size()), 0);
    check("drain_n_empty", 64'(q_n.size()), 0);
  endtask

  // counts negedges until out_valid is seen (from just after an accept edge)
  task automatic wait_lat(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (ov_w || n >= 50) break;
      n++;
    end
  endtask

  initial begin
    int n, run, acc, base;
    bit got;
    reset = 1'b1;
    iv_w = 1'b1; a_w = 16'h1234; b_w = 16'h4321; ci_w = 1'b0; sub_w = 1'b0;
    iv_n = 1'b0; a_n = '0; b_n = '0; ci_n = 1'b0; sub_n = 1'b0;
    ordy_dir_w = 1'b1; ordy_dir_n = 1'b1; rnd_en_w = 1'b0; rnd_en_n = 1'b0;
    ordy_rnd_w = 1'b1; ordy_rnd_n = 1'b1;

    // reset with a transaction presented
    @(posedge clk); @(negedge clk);
    check("rst_in_ready", ir_w, 0);
    check("rst_out_valid", ov_w, 0);
    check("rst_s_out", s_w, 0);
    check("rst_c_out", c_w, 0);
    check("rst_ovf_out", ovf_w, 0);
    @(posedge clk); #1;
    reset = 1'b0; iv_w = 1'b0;
    @(negedge clk);
    check("rst_in_ready_after", ir_w, 1);
    check("rst_out_valid_after", ov_w, 0);
    @(posedge clk); #1;

    // full carry ripple and latency
    send_w(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_lat(n);
    check("latency", 64'(n), 3);
    check("ripple_cs", {c_w, s_w}, 17'h10000);
    check("ripple_ovf", ovf_w, 0);
    @(posedge clk); #1;
    wait_drain();

    // subtraction
    send_w(16'h8000, 16'h0001, 1'b1, 1'b1);
    wait_lat(n);
    check("sub_ovf_cs", {c_w, s_w}, 17'h17FFF);
    check("sub_ovf_ovf", ovf_w, 1);
    @(posedge clk); #1;
    send_w(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_lat(n);
    check("sub_neg_cs", {c_w, s_w}, 17'h0FFFE);
    check("sub_neg_ovf", ovf_w, 0);
    @(posedge clk); #1;
    wait_drain();

    // back-to-back
    run = 0;
    fork
      for (int i = 0; i < 8; i++) send_w(16'(i), 16'(32'h1000 * i), 1'(i & 1), 1'b0);
      begin
        wait_lat(n);
        while (ov_w && run < 20) begin run++; @(negedge clk); end
      end
    join
    check("b2b_first_out", 64'(n), 4);
    check("b2b_run_len", 64'(run), 8);
    @(posedge clk); #1;
    wait_drain();

    // backpressure
    base = n_pop_w; acc = 0;
    ordy_dir_w = 1'b0;
    a_w = 16'($urandom); b_w = 16'($urandom); ci_w = 1'($urandom); sub_w = 1'($urandom); iv_w = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); got = ir_w;
      @(posedge clk); #1;
      if (got) begin
        acc++;
        a_w = 16'($urandom); b_w = 16'($urandom); ci_w = 1'($urandom); sub_w = 1'($urandom);
      end
    end
    check("bp_accepts", 64'(acc), 4);
    @(negedge clk);
    check("bp_in_ready_low", ir_w, 0);
    check("bp_out_valid", ov_w, 1);
    @(posedge clk); #1;
    ordy_dir_w = 1'b1;
    @(negedge clk);
    check("bp_push_pop", {ov_w, ir_w}, 2'b11);
    @(posedge clk); #1;
    iv_w = 1'b0;
    wait_drain();
    check("bp_pop_count", 64'(n_pop_w - base), 5);

    // reset with 3 in flight
    base = n_pop_w;
    for (int i = 0; i < 3; i++) send_w(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_flight_none", 64'(n_pop_w - base), 0);

    // random traffic with random backpressure
    rnd_en_w = 1'b1;
    for (int i = 0; i < 200; i++) send_w(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    wait_drain();
    rnd_en_w = 1'b0;

    // exhaustive 4-bit / 2-stage sweep
    base = n_pop_n;
    rnd_en_n = 1'b1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++)
          for (int sb = 0; sb < 2; sb++)
            send_n(4'(a), 4'(b), 1'(ci), 1'(sb));
    wait_drain();
    rnd_en_n = 1'b0;
    check("sweep_count", 64'(n_pop_n - base), 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
